midi_parser: RTL

//  Byte-level MIDI channel-message decoder that sits between the UART receiver and the polyphony voice allocator.

---
 rtl/midi_parser_if.sv | 21 ++
 rtl/midi_parser.sv | 108 ++++++++++
 2 files changed

// File: rtl/midi_parser_if.sv
// Byte stream from the UART receiver in, decoded note events out to the voice allocator.
// master drives the received bytes; slave is the parser.
interface midi_parser_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [6:0] note_num;
  logic [6:0] note_vel;
  logic       note_on;
  logic       note_off;
  logic       sync_err;

  modport master (
    output byte_in, byte_valid,
    input  note_num, note_vel, note_on, note_off, sync_err
  );

  modport slave (
    input  byte_in, byte_valid,
    output note_num, note_vel, note_on, note_off, sync_err
  );
endinterface

// File: rtl/midi_parser.sv
// MIDI channel-message parser: status/running-status/data framing, Note On/Off strobes.
// One cycle from the final data byte to the strobe; no backpressure, accepts a byte every cycle.
module midi_parser #(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  midi_parser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  localparam logic [3:0] CH = 4'(CHANNEL);

  state_t     state_q, state_d;
  logic [7:0] rs_q, rs_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_num_q, note_num_d;
  logic [6:0] note_vel_q, note_vel_d;
  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic       sync_err_q, sync_err_d;

  logic is_realtime, is_common, two_byte, chan_ok, is_note_on, is_note_off;

  always_comb begin
    is_realtime = bus.byte_in[7:3] == 5'b11111;
    is_common   = bus.byte_in[7:4] == 4'hF;
    two_byte    = (rs_q[7:4] != 4'hC) && (rs_q[7:4] != 4'hD);
    chan_ok     = OMNI || (rs_q[3:0] == CH);
    is_note_on  = rs_q[7:4] == 4'h9;
    is_note_off = rs_q[7:4] == 4'h8;
  end

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    d1_d       = d1_q;
    note_num_d = note_num_q;
    note_vel_d = note_vel_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    sync_err_d = 1'b0;

    if (bus.byte_valid && !is_realtime) begin
      if (bus.byte_in[7]) begin
        // Any status byte restarts the parse, whatever state we were in.
        if (is_common) begin
          rs_d    = 8'h00;
          state_d = (bus.byte_in == 8'hF0) ? SYSEX : IDLE;
        end else begin
          rs_d    = bus.byte_in;
          state_d = WAIT_D1;
        end
      end else begin
        unique case (state_q)
          IDLE: sync_err_d = 1'b1;
          WAIT_D1: begin
            d1_d = bus.byte_in[6:0];
            if (two_byte) state_d = WAIT_D2;
          end
          WAIT_D2: begin
            state_d = WAIT_D1;
            if (chan_ok && is_note_on && (bus.byte_in[6:0] != 7'd0)) begin
              note_on_d  = 1'b1;
              note_num_d = d1_q;
              note_vel_d = bus.byte_in[6:0];
            end else if (chan_ok && (is_note_on || is_note_off)) begin
              note_off_d = 1'b1;
              note_num_d = d1_q;
              note_vel_d = 7'd0;
            end
          end
          SYSEX: ;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rs_q       <= 8'h00;
      d1_q       <= 7'd0;
      note_num_q <= 7'd0;
      note_vel_q <= 7'd0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      d1_q       <= d1_d;
      note_num_q <= note_num_d;
      note_vel_q <= note_vel_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.note_num = note_num_q;
  assign bus.note_vel = note_vel_q;
  assign bus.note_on  = note_on_q;
  assign bus.note_off = note_off_q;
  assign bus.sync_err = sync_err_q;
endmodule
